sha_round_sequencer: RTL and testbench

Parametrised successor to the hashing module's message counter. It sequences one hash block through two phases:
- message-schedule extension, counting MSG_WORDS..ROUNDS-1;
- compression rounds, counting 0..ROUNDS-1.

It adds a start/busy/done handshake, stall, abort and phase strobes. It sits between the hash controller and the schedule/round datapath and supplies the word index used by both.

---
 rtl/sha_seq_pkg.sv | 9 +
 rtl/sha_idx_counter.sv | 27 ++
 rtl/sha_round_sequencer.sv | 103 ++++++++++
 tb/tb_sha_round_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha_seq_pkg.sv
// Shared types and constants for the SHA round sequencer.
// The sequencer phase enum lives here together with the standard round counts.
package sha_seq_pkg;
  typedef enum logic [1:0] {IDLE, EXT, RND, DONE} seq_state_e;

  localparam int SHA1_ROUNDS   = 80;
  localparam int SHA256_ROUNDS = 64;
  localparam int SHA_MSG_WORDS = 16;
endpackage

// File: rtl/sha_idx_counter.sv
// Loadable word/round index counter; one cycle from load/enable to new count.
// Priority: load > hold > enable, so a pending load wins over a freeze.
module sha_idx_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             hold,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en && !hold) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;
endmodule

// File: rtl/sha_round_sequencer.sv
// Sequences one hash block: schedule extension, compression rounds, one-cycle done.
// Optional block counter enabled by macro SHA_SEQ_BLK_CNT_EN; stall freezes, abort returns to IDLE.
module sha_round_sequencer
  import sha_seq_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int ROUNDS    = SHA1_ROUNDS,
  parameter int MSG_WORDS = SHA_MSG_WORDS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             skip_ext,
  input  logic             stall,
  input  logic             abort,
  output logic [CNT_W-1:0] msg_cnt,
  output logic             ext_en,
  output logic             round_en,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic [31:0]      blk_cnt
);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] LP_EXT0 = CNT_W'(MSG_WORDS);

  generate
    if (MSG_WORDS >= ROUNDS || ROUNDS > (1 << CNT_W)) begin : g_param_chk
      $error("sha_round_sequencer: need MSG_WORDS < ROUNDS <= 2**CNT_W");
    end
  endgenerate

  seq_state_e       r_state;
  logic             w_idle_like;
  logic             w_run;
  logic             w_at_last;
  logic             w_accept;
  logic             w_cnt_load;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_cnt_val;
  logic [CNT_W-1:0] w_cnt;

  assign w_idle_like = (r_state == IDLE) || (r_state == DONE);
  assign w_run       = (r_state == EXT) || (r_state == RND);
  assign w_at_last   = w_run && (w_cnt == LP_LAST);
  assign w_accept    = w_idle_like && start && !stall && !abort;

  // Counter holds ROUNDS-1 on the RND->DONE step; only EXT's final word reloads zero.
  assign w_cnt_load = abort || (!stall && (w_idle_like || ((r_state == EXT) && w_at_last)));
  assign w_cnt_val  = (w_accept && !skip_ext) ? LP_EXT0 : '0;
  assign w_cnt_en   = w_run && !w_at_last;

  sha_idx_counter #(.CNT_W(CNT_W)) u_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_cnt_load),
    .load_val (w_cnt_val),
    .en       (w_cnt_en),
    .hold     (stall),
    .cnt      (w_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (abort) begin
      r_state <= IDLE;
    end else if (!stall) begin
      case (r_state)
        IDLE, DONE: begin
          if (start) r_state <= skip_ext ? RND : EXT;
          else       r_state <= IDLE;
        end
        EXT:     if (w_at_last) r_state <= RND;
        RND:     if (w_at_last) r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SHA_SEQ_BLK_CNT_EN
  logic [31:0] r_blk_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blk_cnt <= '0;
    end else if (!abort && !stall && (r_state == RND) && w_at_last) begin
      r_blk_cnt <= r_blk_cnt + 32'd1;
    end
  end

  assign blk_cnt = r_blk_cnt;
`else
  assign blk_cnt = '0;
`endif

  assign msg_cnt  = w_cnt;
  assign ext_en   = (r_state == EXT);
  assign round_en = (r_state == RND);
  assign last     = w_at_last;
  assign busy     = w_run;
  assign done     = (r_state == DONE);
endmodule

// File: tb/tb_sha_round_sequencer.sv
// Bench for sha_round_sequencer: SHA-1 (80 rounds) and SHA-256 (64 rounds) instances share stimulus.
// Each block is modelled as a flat list of (phase, index) items walked one per unstalled cycle.
module tb_sha_round_sequencer;
  logic clk = 1'b0;
  logic rst_n, start, skip_ext, stall, abort;

  logic [7:0]  msg_cnt0;
  logic [5:0]  msg_cnt1;
  logic        ext_en0, round_en0, last0, busy0, done0;
  logic        ext_en1, round_en1, last1, busy1, done1;
  logic [31:0] blk_cnt0, blk_cnt1;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  always #5 clk = ~clk;

  sha_round_sequencer #(.CNT_W(8), .ROUNDS(80), .MSG_WORDS(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .skip_ext(skip_ext), .stall(stall), .abort(abort),
    .msg_cnt(msg_cnt0), .ext_en(ext_en0), .round_en(round_en0), .last(last0),
    .busy(busy0), .done(done0), .blk_cnt(blk_cnt0));

  sha_round_sequencer #(.CNT_W(6), .ROUNDS(64), .MSG_WORDS(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .skip_ext(skip_ext), .stall(stall), .abort(abort),
    .msg_cnt(msg_cnt1), .ext_en(ext_en1), .round_en(round_en1), .last(last1),
    .busy(busy1), .done(done1), .blk_cnt(blk_cnt1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %0d (0x%0h) want %0d (0x%0h)", tag, n, got, got, exp, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 extension, 2 rounds, 3 done.
  int          m_rounds[2] = '{80, 64};
  int          m_words = 16;
  bit          m_act[2];
  bit          m_skip[2];
  int          m_pos[2];
  logic [31:0] m_blk[2];

  function automatic void item_at(input int k, output int ph, output int idx);
    int ext_len;
    ext_len = m_skip[k] ? 0 : (m_rounds[k] - m_words);
    if (!m_act[k])                           begin ph = 0; idx = 0; end
    else if (m_pos[k] < ext_len)             begin ph = 1; idx = m_words + m_pos[k]; end
    else if (m_pos[k] < ext_len + m_rounds[k]) begin ph = 2; idx = m_pos[k] - ext_len; end
    else                                     begin ph = 3; idx = m_rounds[k] - 1; end
  endfunction

  task automatic model_step();
    int ph, idx;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_act[k] = 1'b0;
        m_blk[k] = '0;
      end else if (abort) begin
        m_act[k] = 1'b0;
      end else if (!stall) begin
        item_at(k, ph, idx);
        if (ph == 1 || ph == 2) begin
          m_pos[k]++;
          item_at(k, ph, idx);
`ifdef SHA_SEQ_BLK_CNT_EN
          if (ph == 3) m_blk[k] = m_blk[k] + 32'd1;
`endif
        end else if (start) begin
          m_act[k]  = 1'b1;
          m_skip[k] = skip_ext;
          m_pos[k]  = 0;
        end else begin
          m_act[k] = 1'b0;
        end
      end
    end
  endtask

  function automatic logic [4:0] exp_flags(input int k);
    int ph, idx;
    bit run;
    item_at(k, ph, idx);
    run = (ph == 1) || (ph == 2);
    return {ph == 1, ph == 2, run && (idx == m_rounds[k] - 1), run, ph == 3};
  endfunction

  function automatic logic [31:0] exp_cnt(input int k);
    int ph, idx;
    item_at(k, ph, idx);
    return 32'(idx);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    n++;
    #1;
    chk("cnt80",   32'(msg_cnt0), exp_cnt(0));
    chk("flags80", 32'({ext_en0, round_en0, last0, busy0, done0}), 32'(exp_flags(0)));
    chk("blk80",   blk_cnt0, m_blk[0]);
    chk("cnt64",   32'(msg_cnt1), exp_cnt(1));
    chk("flags64", 32'({ext_en1, round_en1, last1, busy1, done1}), 32'(exp_flags(1)));
    chk("blk64",   blk_cnt1, m_blk[1]);
  endtask

  task automatic drive(input bit r, input bit st, input bit sk, input bit sl, input bit ab);
    rst_n = r; start = st; skip_ext = sk; stall = sl; abort = ab;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    drive(1, 0, 0, 0, 0);
  endtask

  int d0, d1, nd;
  logic [31:0] blk_save;
  logic [31:0] exp_blk3;

  initial begin
`ifdef SHA_SEQ_BLK_CNT_EN
    exp_blk3 = 32'd3;
`else
    exp_blk3 = 32'd0;
`endif
    do_reset();

    // Full SHA-1 block with extension: done at cycle 145, busy low there.
    drive(1, 1, 0, 0, 0);
    n = 0; tick();
    chk("t1_first_idx", 32'(msg_cnt0), 32'd16);
    drive(1, 0, 0, 0, 0);
    while (!done0 && n < 300) tick();
    chk("t1_done_cycle", 32'(n), 32'd145);
    chk("t1_busy_at_done", 32'(busy0), 32'd0);
    tick();

    // skip_ext: done at 81 (80 rounds) and 65 (64 rounds).
    do_reset();
    drive(1, 1, 1, 0, 0);
    n = 0; d0 = -1; d1 = -1;
    tick();
    drive(1, 0, 0, 0, 0);
    while ((d0 < 0 || d1 < 0) && n < 200) begin
      if (done0 && d0 < 0) d0 = n;
      if (done1 && d1 < 0) d1 = n;
      tick();
    end
    chk("t2_done80", 32'(d0), 32'd81);
    chk("t2_done64", 32'(d1), 32'd65);

    // Three-cycle stall at EXT index 40 delays done by 3.
    do_reset();
    drive(1, 1, 0, 0, 0);
    n = 0; tick();
    drive(1, 0, 0, 0, 0);
    while (msg_cnt0 != 8'd40 && n < 200) tick();
    chk("t3_reach40", 32'(msg_cnt0), 32'd40);
    drive(1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_frozen", 32'(msg_cnt0), 32'd40);
    end
    drive(1, 0, 0, 0, 0);
    tick();
    chk("t3_resume", 32'(msg_cnt0), 32'd41);
    while (!done0 && n < 400) tick();
    chk("t3_done_cycle", 32'(n), 32'd148);
    tick();

    // Abort in RND at index 10: IDLE, no done, blk_cnt unchanged.
    drive(1, 1, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    while (!(round_en0 && msg_cnt0 == 8'd10) && n < 2000) tick();
    chk("t4_reach10", 32'(msg_cnt0), 32'd10);
    blk_save = blk_cnt0;
    drive(1, 0, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0, 0);
    chk("t4_abort_busy", 32'(busy0), 32'd0);
    chk("t4_abort_cnt", 32'(msg_cnt0), 32'd0);
    nd = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done0) nd++;
    end
    chk("t4_no_done", 32'(nd), 32'd0);
    chk("t4_blk_same", blk_cnt0, blk_save);

    // start held with skip_ext: back-to-back blocks, done every 81 cycles.
    do_reset();
    drive(1, 1, 1, 0, 0);
    n = 0; nd = 0; d0 = 0;
    for (int i = 0; i < 243; i++) begin
      tick();
      if (done0) begin
        nd++;
        chk("t5_done_spacing", 32'(n - d0), 32'd81);
        d0 = n;
      end
      if (n == 82) chk("t5_restart_idx", 32'(msg_cnt0), 32'd0);
    end
    chk("t5_done_count", 32'(nd), 32'd3);
    chk("t5_blk_cnt", blk_cnt0, exp_blk3);
    drive(1, 0, 0, 0, 0);
    tick();

    // Reset mid-EXT with abort and start: reset wins, start not taken.
    do_reset();
    drive(1, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    while (msg_cnt0 != 8'd50 && n < 5000) tick();
    chk("t6_reach50", 32'(msg_cnt0), 32'd50);
    drive(0, 1, 0, 0, 1);
    tick();
    chk("t6_rst_out", 32'({msg_cnt0, ext_en0, round_en0, last0, busy0, done0}), 32'd0);
    chk("t6_rst_blk", blk_cnt0, 32'd0);
    drive(1, 0, 0, 0, 0);
    tick();
    chk("t6_still_idle", 32'(busy0), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom % 600) != 0, ($urandom % 4) == 0, $urandom % 2,
            ($urandom % 10) == 0, ($urandom % 250) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
